// File: rtl/le_cluster_pkg.sv
// le_cluster shared types and sizing helpers.
// Field widths are derived here so cell and top agree.
package le_cluster_pkg;

  typedef enum logic [1:0] {
    UNCONF = 2'd0,
    CONF   = 2'd1,
    ERR    = 2'd2
  } cfg_state_t;

  function automatic int sel_w(
    input int num_in,
    input int num_le
  );
    return $clog2(num_in + num_le);
  endfunction

  function automatic int le_cfg_w(
    input int lut_k,
    input int sw
  );
    return (2 ** lut_k) + lut_k * sw + 1;
  endfunction

  function automatic int cfg_bits(
    input int num_le,
    input int lw
  );
    return num_le * lw;
  endfunction

endpackage

// File: rtl/le_cluster_le_cell.sv
// One logic element: input selects, K-LUT, flip-flop
// and registered/combinational output mux.
module le_cell
  import le_cluster_pkg::*;
#(
  parameter int LUT_K   = 4,
  parameter int SEL_W   = 5,
  parameter int NUM_SRC = 20,
  parameter int CFG_W   = le_cfg_w(LUT_K, SEL_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CFG_W-1:0]   cfg,
  input  logic [NUM_SRC-1:0] src,
  input  logic               ff_en,
  input  logic               out_en,
  output logic               q,
  output logic               out
);

  localparam int MASK_W = 2 ** LUT_K;

  logic [MASK_W-1:0] mask;
  logic              reg_mode;
  logic [LUT_K-1:0]  lin;
  logic              lut;

  assign mask     = cfg[MASK_W-1:0];
  assign reg_mode = cfg[CFG_W-1];

  // Select codes beyond the last source fall through to 0.
  always_comb begin
    lin = '0;
    for (int k = 0; k < LUT_K; k++) begin
      for (int s = 0; s < NUM_SRC; s++) begin
        if (cfg[MASK_W+k*SEL_W +: SEL_W] == SEL_W'(s))
          lin[k] = src[s];
      end
    end
  end

  assign lut = mask[lin];

  always_ff @(posedge clk) begin
    if (rst)
      q <= 1'b0;
    else if (ff_en)
      q <= lut;
  end

  assign out = out_en & (reg_mode ? q : lut);

endmodule

// File: rtl/le_cluster.sv
// Cluster of LUT-based logic elements programmed through
// a serial configuration chain with load/overflow tracking.
module le_cluster
  import le_cluster_pkg::*;
#(
  parameter int NUM_LE = 4,
  parameter int LUT_K  = 4,
  parameter int NUM_IN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              config_en,
  input  logic              config_data_in,
  output logic              config_data_out,
  input  logic              le_en,
  input  logic [NUM_IN-1:0] cl_in,
  output logic [NUM_LE-1:0] cl_out,
  output logic              cfg_done,
  output logic              cfg_err
);

  localparam int SEL_W    = sel_w(NUM_IN, NUM_LE);
  localparam int LE_CFG_W = le_cfg_w(LUT_K, SEL_W);
  localparam int CFG_BITS = cfg_bits(NUM_LE, LE_CFG_W);
  localparam int NUM_SRC  = NUM_IN + NUM_LE;
  localparam int CW       = $clog2(CFG_BITS + 2);

  logic [CFG_BITS-1:0] chain;
  logic [CW-1:0]       count;
  logic [NUM_LE-1:0]   q;
  logic [NUM_SRC-1:0]  src;
  logic                ff_en;
  logic                out_en;
  cfg_state_t          state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst)
      chain <= '0;
    else if (config_en)
      chain <= {chain[CFG_BITS-2:0], config_data_in};
  end

  assign config_data_out = chain[CFG_BITS-1];

  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (config_en && count != CW'(CFG_BITS + 1))
      count <= count + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= UNCONF;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      UNCONF:
        if (config_en && count == CW'(CFG_BITS - 1))
          state_nxt = CONF;
      CONF:
        if (config_en)
          state_nxt = ERR;
      ERR:
        state_nxt = ERR;
      default:
        state_nxt = UNCONF;
    endcase
  end

  assign cfg_done = (state == CONF);
  assign cfg_err  = (state == ERR);

  // LEs run only on a complete, quiescent configuration.
  assign out_en = cfg_done & ~config_en;
  assign ff_en  = le_en & out_en;

  // Feedback comes from flops only, so no LUT-to-LUT loops.
  assign src = {q, cl_in};

  for (genvar j = 0; j < NUM_LE; j++) begin : g_le
    le_cell #(
      .LUT_K  (LUT_K),
      .SEL_W  (SEL_W),
      .NUM_SRC(NUM_SRC),
      .CFG_W  (LE_CFG_W)
    ) u_cell (
      .clk   (clk),
      .rst   (rst),
      .cfg   (chain[j*LE_CFG_W +: LE_CFG_W]),
      .src   (src),
      .ff_en (ff_en),
      .out_en(out_en),
      .q     (q[j]),
      .out   (cl_out[j])
    );
  end

endmodule

// File: tb/tb_le_cluster.sv
// Directed bench for le_cluster: reset, load, registered
// feedback, select range, overflow and chain passthrough.
module tb_le_cluster;

  localparam int CFG = 148;

  logic        clk = 1'b0;
  logic        rst;
  logic        config_en;
  logic        config_data_in;
  logic        config_data_out;
  logic        le_en;
  logic [15:0] cl_in;
  logic [3:0]  cl_out;
  logic        cfg_done;
  logic        cfg_err;

  int tests = 0;
  int fails = 0;

  le_cluster dut (
    .clk            (clk),
    .rst            (rst),
    .config_en      (config_en),
    .config_data_in (config_data_in),
    .config_data_out(config_data_out),
    .le_en          (le_en),
    .cl_in          (cl_in),
    .cl_out         (cl_out),
    .cfg_done       (cfg_done),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic b);
    config_en      = 1'b1;
    config_data_in = b;
    tick();
    config_en      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic load(input logic [CFG-1:0] c);
    for (int i = CFG - 1; i >= 0; i--) begin
      shift(c[i]);
      if (i == 1)
        check("done_early", cfg_done, 0);
    end
  endtask

  function automatic logic [36:0] le_f(
    input logic [15:0] m,
    input logic [4:0]  s0,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [4:0]  s3,
    input logic        rm
  );
    return {rm, s3, s2, s1, s0, m};
  endfunction

  logic [CFG-1:0] cfg_a;
  logic [CFG-1:0] cfg_b;
  logic [15:0]    pats[7];
  logic           bits[296];
  logic           f0, f1;

  initial begin
    rst            = 1'b1;
    config_en      = 1'b0;
    config_data_in = 1'b0;
    le_en          = 1'b0;
    cl_in          = '0;
    tick();
    do_reset();

    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_out", cl_out, 0);
    check("rst_dout", config_data_out, 0);

    // Reset asserted during a shift discards the chain.
    for (int i = 0; i < CFG; i++) shift(1'b1);
    check("ones_dout", config_data_out, 1);
    check("ones_done", cfg_done, 1);
    rst            = 1'b1;
    config_en      = 1'b1;
    config_data_in = 1'b1;
    tick();
    rst       = 1'b0;
    config_en = 1'b0;
    check("midrst_dout", config_data_out, 0);
    check("midrst_done", cfg_done, 0);
    check("midrst_out", cl_out, 0);

    // Combinational 4-input AND on LE0.
    cfg_a = {le_f(16'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0),
             le_f(16'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0),
             le_f(16'h0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0),
             le_f(16'h8000, 5'd0, 5'd1, 5'd2, 5'd3, 1'b0)};
    load(cfg_a);
    check("load_done", cfg_done, 1);
    check("load_err", cfg_err, 0);
    cl_in = 16'h000F;
    #1;
    check("and_F", cl_out, 4'b0001);
    cl_in = 16'h000E;
    #1;
    check("and_E", cl_out, 4'b0000);

    // LE0 registered AND, LE1 registered NOT ff0,
    // LE2 all selects out of range, LE3 passes cl_in[0].
    do_reset();
    cfg_b = {le_f(16'hFFFE, 5'd0, 5'd31, 5'd31, 5'd31, 1'b0),
             le_f(16'hFFFE, 5'd20, 5'd31, 5'd31, 5'd31, 1'b0),
             le_f(16'h5555, 5'd16, 5'd31, 5'd31, 5'd31, 1'b1),
             le_f(16'h8000, 5'd0, 5'd1, 5'd2, 5'd3, 1'b1)};
    load(cfg_b);
    check("reg_done", cfg_done, 1);
    pats[0] = 16'hFFFF;
    pats[1] = 16'hFFFF;
    pats[2] = 16'hFFF0;
    pats[3] = 16'hFFFF;
    pats[4] = 16'hFFF0;
    pats[5] = 16'hFFF0;
    pats[6] = 16'hFFFF;
    f0    = 1'b0;
    f1    = 1'b0;
    le_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cl_in = pats[i];
      #1;
      check("reg_pre", cl_out, {pats[i][0], 1'b0, f1, f0});
      tick();
      {f1, f0} = {~f0, &pats[i][3:0]};
      check("reg_post", cl_out, {pats[i][0], 1'b0, f1, f0});
    end
    le_en = 1'b0;
    cl_in = (f0 ? 16'hFFF0 : 16'hFFFF);
    tick();
    tick();
    check("hold", cl_out[1:0], {f1, f0});

    // Extra shift overflows; output gated during shift.
    cl_in          = 16'hFFFF;
    config_en      = 1'b1;
    config_data_in = 1'b0;
    #1;
    check("shift_gate", cl_out, 0);
    tick();
    config_en = 1'b0;
    check("ovf_err", cfg_err, 1);
    check("ovf_done", cfg_done, 0);
    check("ovf_out", cl_out, 0);
    for (int i = 0; i < 3; i++) shift(1'b0);
    tick();
    check("ovf_err_hold", cfg_err, 1);
    check("ovf_done_hold", cfg_done, 0);
    do_reset();
    check("ovf_clr", cfg_err, 0);

    // Chain reproduces input bits after CFG cycles.
    for (int i = 0; i < 296; i++)
      bits[i] = 1'($urandom_range(0, 1));
    for (int k = 1; k <= 296; k++) begin
      shift(bits[k-1]);
      if (k >= CFG && k < 296)
        check("pass", config_data_out, bits[k-CFG]);
    end
    check("pass_err", cfg_err, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/le_cluster.md
LE_CLUSTER -- requirements
Module: le_cluster

Interface
REQ-001 SHALL have parameter NUM_LE, default 4, the number of logic elements in the cluster.
REQ-002 SHALL have parameter LUT_K, default 4, the number of inputs per LUT; the LUT is 2**LUT_K bits.
REQ-003 SHALL have parameter NUM_IN, default 16, the number of cluster routing inputs.
REQ-004 SHALL have derived constant SEL_W = clog2(NUM_IN+NUM_LE), the width of each input-select field.
REQ-005 SHALL have derived constant LE_CFG_W = 2**LUT_K + LUT_K*SEL_W + 1, the configuration bits per LE.
REQ-006 SHALL have derived constant CFG_BITS = NUM_LE*LE_CFG_W.
REQ-007 SHALL have port clk, input, 1 bit: the single clock for configuration and logic; the block is single-clock; reset is synchronous, active-high.
REQ-008 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-009 SHALL have port config_en, input, 1 bit: when high, shift the config chain by one bit per clk.
REQ-010 SHALL have port config_data_in, input, 1 bit: serial config bit in.
REQ-011 SHALL have port config_data_out, input/output as follows: output, 1 bit, serial config bit out (chain tail).
REQ-012 SHALL have port le_en, input, 1 bit: LE flip-flop clock enable.
REQ-013 SHALL have port cl_in, input, NUM_IN bits: routing inputs.
REQ-014 SHALL have port cl_out, output, NUM_LE bits: LE outputs.
REQ-015 SHALL have port cfg_done, output, 1 bit: exactly CFG_BITS bits have been shifted since reset.
REQ-016 SHALL have port cfg_err, output, 1 bit: more than CFG_BITS bits have been shifted (sticky).

Function
REQ-017 The config chain SHALL be a CFG_BITS shift register; when config_en=1, chain[0]<=config_data_in and chain[i]<=chain[i-1]; config_data_out SHALL equal chain[CFG_BITS-1].
REQ-018 The LE j field SHALL be chain[j*LE_CFG_W +: LE_CFG_W], with LSB first: LUT mask [2**LUT_K-1:0], then sel[0..LUT_K-1] each SEL_W bits, then reg_mode as the MSB.
REQ-019 Select index s SHALL map as follows: s<NUM_IN selects cl_in[s]; NUM_IN<=s<NUM_IN+NUM_LE selects the registered feedback ff[s-NUM_IN]; larger values select constant 0.
REQ-020 LUT output SHALL be mask[{in[LUT_K-1],...,in[0]}], combinational.
REQ-021 Each LE SHALL own flip-flop ff[j]; when le_en=1, cfg_done=1 and config_en=0, ff[j]<=LUT output; otherwise it holds.
REQ-022 cl_out[j] SHALL be ff[j] when reg_mode=1, and the LUT output otherwise; cl_out SHALL be forced to 0 whenever cfg_done=0 or config_en=1.
REQ-023 Bit counter: a counter wide enough for CFG_BITS+1 SHALL increment on each config_en cycle and saturate at CFG_BITS+1.
REQ-024 cfg_done SHALL be 1 exactly when count==CFG_BITS; it updates the cycle after the final shift.
REQ-025 cfg_err SHALL set when a shift occurs with count==CFG_BITS and hold until rst; while cfg_err=1, cfg_done SHALL be 0.
REQ-026 The block SHALL have a three-state FSM: UNCONF (count<CFG_BITS), CONF (count==CFG_BITS), ERR. Transitions: UNCONF->CONF on the final shift; CONF->ERR on any shift; ERR is terminal until rst.
REQ-027 Feedback through reg_mode=0 LEs SHALL NOT form combinational loops; feedback is taken only from ff, never from the LUT output.

Reset
REQ-028 On rst=1, the chain, ff, counter and cfg_err SHALL clear to 0 at the next clk edge, and the FSM SHALL enter UNCONF; cl_out=0, cfg_done=0 and config_data_out=0 follow.
REQ-029 rst SHALL take priority over config_en and le_en; reset mid-load SHALL discard partial configuration.

Structure
REQ-030 A package le_cluster_pkg SHALL hold the FSM enum (UNCONF, CONF, ERR) and the functions computing SEL_W, LE_CFG_W and CFG_BITS.
REQ-031 There SHALL be one sub-module, le_cell (LUT, input muxes, ff, output mux), instantiated NUM_LE times.

Verification
REQ-032 Reset: assert rst during a shift -> the next cycle shows count=0, cfg_done=0, cl_out=0 and config_data_out=0.
REQ-033 Load: default parameters (CFG_BITS=4*(16+20+1)=148), shift 148 bits with LE0 mask=16'h8000, sel=0,1,2,3 and reg_mode=0; drive cl_in[3:0]=4'hF -> cfg_done=1 and cl_out[0]=1; drive cl_in[3:0]=4'hE -> cl_out[0]=0.
REQ-034 Registered path: LE1 mask=16'h5555 with sel0=16 (ff[0]) and reg_mode=1, with LE0 configured as a registered AND; assert le_en -> cl_out[1] toggles with one-cycle latency relative to ff[0]; with le_en=0, cl_out holds.
REQ-035 Overflow: shift 149 bits -> cfg_err=1 and cfg_done=0 thereafter, until rst.
REQ-036 Passthrough: shift 296 bits -> config_data_out reproduces the first 148 input bits, delayed by 148 cycles.
REQ-037 Out-of-range select: sel=31 -> that LUT input reads 0, checked with mask=16'hFFFE.
